// File: rtl/noc_parameters.sv
// Shared NoC definitions for the AXI NI: flit type codes, request header field
// offsets, request header record and the AXI3 LOCK encoding for locked accesses.
package noc_parameters;

  localparam int FLIT_W   = 80;
  localparam int PATH_W   = 7;
  localparam int HDR_ID_W = 4;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  localparam logic [1:0] AXI_LOCK_LOCKED = 2'b10;

  // Header flit field offsets (LSB of each field)
  localparam int PATH_LSB  = 73;
  localparam int SRC_LSB   = 69;
  localparam int READ_BIT  = 68;
  localparam int LOCK_BIT  = 67;
  localparam int ID_LSB    = 63;
  localparam int ADDR_LSB  = 31;
  localparam int LEN_LSB   = 27;
  localparam int SIZE_LSB  = 24;
  localparam int BURST_LSB = 22;
  localparam int CACHE_LSB = 18;
  localparam int PROT_LSB  = 15;

  // Payload flit field offsets
  localparam int WDATA_LSB = 16;
  localparam int WSTRB_LSB = 8;
  localparam int WLAST_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } prio_t;

  typedef struct packed {
    logic                is_read;
    logic [1:0]          lock;
    logic [HDR_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [3:0]          cache;
    logic [2:0]          prot;
  } req_hdr_t;

  function automatic logic [FLIT_W-1:0] build_header(
    input logic [PATH_W-1:0] path,
    input logic [3:0]        source,
    input req_hdr_t          h
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[PATH_LSB +: PATH_W]   = path;
    f[SRC_LSB +: 4]         = source;
    f[READ_BIT]             = h.is_read;
    f[LOCK_BIT]             = (h.lock == AXI_LOCK_LOCKED);
    f[ID_LSB +: HDR_ID_W]   = h.id;
    f[ADDR_LSB +: 32]       = h.addr;
    f[LEN_LSB +: 4]         = h.len;
    f[SIZE_LSB +: 3]        = h.size;
    f[BURST_LSB +: 2]       = h.burst;
    f[CACHE_LSB +: 4]       = h.cache;
    f[PROT_LSB +: 3]        = h.prot;
    f[1:0]                  = h.is_read ? FT_HEAD_TAIL : FT_HEAD;
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] build_payload(
    input logic [63:0] data,
    input logic [7:0]  strb,
    input logic        last_in,
    input logic        tail
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[WDATA_LSB +: 64] = data;
    f[WSTRB_LSB +: 8]  = strb;
    f[WLAST_BIT]       = last_in;
    f[1:0]             = tail ? FT_TAIL : FT_BODY;
    return f;
  endfunction

endpackage

// File: rtl/axi_ni_request_packetizer.sv
// AXI3 request packetizer for the NI initiator: turns AR and AW/W transactions
// into a header flit (plus one payload flit per write beat) for the NI output buffer.
module axi_ni_request_packetizer
  import noc_parameters::*;
#(
  parameter int FLIT_WIDTH = 80,
  parameter int ID_WD      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            SOURCE,
  output logic [3:0]            lut_address,
  input  logic [PATH_W-1:0]     lut_path,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic                  valid,
  input  logic                  stall,
  input  logic [ID_WD-1:0]      ARID,
  input  logic [31:0]           ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ID_WD-1:0]      AWID,
  input  logic [31:0]           AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [63:0]           WDATA,
  input  logic [7:0]            WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  wlast_err
);

  state_t            state_q, state_d;
  prio_t             prio_q, prio_d;
  req_hdr_t          hdr_q, hdr_d;
  logic [3:0]        beat_q, beat_d;
  logic              wlast_err_q, wlast_err_d;
  logic [FLIT_W-1:0] flit_c;
  logic              beat_is_last;

  assign lut_address  = hdr_q.addr[31:28];
  assign beat_is_last = (beat_q == hdr_q.len);
  assign flit         = flit_c;
  assign wlast_err    = wlast_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= PRIO_READ;
      hdr_q       <= '0;
      beat_q      <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      hdr_q       <= hdr_d;
      beat_q      <= beat_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  // Readies are gated by rst so they read 0 while reset is held, even with VALIDs up.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    hdr_d       = hdr_q;
    beat_d      = beat_q;
    wlast_err_d = wlast_err_q;
    ARREADY     = 1'b0;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    valid       = 1'b0;
    flit_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (!rst) begin
          ARREADY = ARVALID && (!AWVALID || prio_q == PRIO_READ);
          AWREADY = AWVALID && (!ARVALID || prio_q == PRIO_WRITE);
        end
        if (ARREADY) begin
          hdr_d.is_read = 1'b1;
          hdr_d.lock    = ARLOCK;
          hdr_d.id      = HDR_ID_W'(ARID);
          hdr_d.addr    = ARADDR;
          hdr_d.len     = ARLEN;
          hdr_d.size    = ARSIZE;
          hdr_d.burst   = ARBURST;
          hdr_d.cache   = ARCACHE;
          hdr_d.prot    = ARPROT;
          state_d       = ST_HDR;
        end else if (AWREADY) begin
          hdr_d.is_read = 1'b0;
          hdr_d.lock    = AWLOCK;
          hdr_d.id      = HDR_ID_W'(AWID);
          hdr_d.addr    = AWADDR;
          hdr_d.len     = AWLEN;
          hdr_d.size    = AWSIZE;
          hdr_d.burst   = AWBURST;
          hdr_d.cache   = AWCACHE;
          hdr_d.prot    = AWPROT;
          state_d       = ST_HDR;
        end
      end

      ST_HDR: begin
        valid  = 1'b1;
        flit_c = build_header(lut_path, SOURCE, hdr_q);
        if (!stall) begin
          prio_d = (prio_q == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
          if (hdr_q.is_read) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = '0;
            state_d = ST_DATA;
          end
        end
      end

      // The tail is chosen from the beat counter; WLAST is only cross-checked.
      ST_DATA: begin
        valid  = WVALID;
        WREADY = !stall;
        flit_c = build_payload(WDATA, WSTRB, WLAST, beat_is_last);
        if (WVALID && !stall) begin
          beat_d = beat_q + 4'd1;
          if (WLAST != beat_is_last) begin
            wlast_err_d = 1'b1;
          end
          if (beat_is_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_ni_request_packetizer.sv
// Randomized self-checking bench for axi_ni_request_packetizer with a
// transaction-level model of the expected flit stream, arbitration and wlast_err.
module tb_axi_ni_request_packetizer;

  logic        clk;
  logic        rst;
  logic [3:0]  SOURCE;
  logic [3:0]  lut_address;
  logic [6:0]  lut_path;
  logic [79:0] flit;
  logic        valid;
  logic        stall;
  logic [3:0]  ARID, AWID;
  logic [31:0] ARADDR, AWADDR;
  logic [3:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic [1:0]  ARLOCK, AWLOCK;
  logic [3:0]  ARCACHE, AWCACHE;
  logic [2:0]  ARPROT, AWPROT;
  logic        ARVALID, ARREADY, AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        wlast_err;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } txn_t;

  typedef struct {
    logic [79:0] f;
    bit          pay;
  } exp_t;

  logic [6:0]  lut [16];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic        wl [16];
  exp_t        expq [$];
  bit          model_prio;
  bit          exp_err;
  int          checks = 0;
  int          fails  = 0;

  assign lut_path = lut[lut_address];

  axi_ni_request_packetizer #(.FLIT_WIDTH(80), .ID_WD(4)) dut (
    .clk(clk), .rst(rst), .SOURCE(SOURCE),
    .lut_address(lut_address), .lut_path(lut_path),
    .flit(flit), .valid(valid), .stall(stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .wlast_err(wlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [79:0] exp_header(input bit is_read, input txn_t t);
    return {lut[t.addr[31:28]], SOURCE, is_read, t.lock == 2'b10, t.id, t.addr,
            t.len, t.size, t.burst, t.cache, t.prot, 13'd0, is_read ? 2'b11 : 2'b01};
  endfunction

  function automatic logic [79:0] exp_payload(input int i, input logic [3:0] len);
    return {wd[i], ws[i], wl[i], 5'd0, (i == int'(len)) ? 2'b10 : 2'b00};
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.id    = 4'($urandom);
    t.addr  = $urandom;
    t.len   = 4'($urandom);
    t.size  = 3'($urandom);
    t.burst = 2'($urandom);
    t.lock  = 2'($urandom);
    t.cache = 4'($urandom);
    t.prot  = 3'($urandom);
    return t;
  endfunction

  task automatic fill_wdata(input logic [3:0] len, input bit corrupt);
    int k;
    for (int i = 0; i < 16; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'($urandom);
      wl[i] = (i == int'(len));
    end
    if (corrupt) begin
      k = int'($urandom_range(int'(len)));
      wl[k] = ~wl[k];
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ARVALID = 1'b1;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    stall   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", ARREADY, 0);
    checkOutput("rst_awready", AWREADY, 0);
    checkOutput("rst_wready", WREADY, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_flit", flit, 0);
    checkOutput("rst_wlast_err", wlast_err, 0);
    checkOutput("rst_lut_address", lut_address, 0);
    ARVALID    = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    rst        = 1'b0;
    model_prio = 1'b0;
    exp_err    = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
  endtask

  // Runs one read and/or one write to completion, observing every cycle on the falling edge.
  task automatic applyStimulus(input bit do_rd, input bit do_wr, input txn_t rt, input txn_t wt,
                               input int stall_pct, input bit burst, input int abort_after);
    int   cycles, w_idx, pay_seen;
    bit   hdr_chk, ar_hs, aw_hs, w_hs, xfer, idle, exp_rd, done;
    logic [3:0] chk_nib;
    exp_t e;
    cycles = 0; w_idx = 0; pay_seen = 0; hdr_chk = 0; done = 0; chk_nib = '0;
    ARID = rt.id; ARADDR = rt.addr; ARLEN = rt.len; ARSIZE = rt.size;
    ARBURST = rt.burst; ARLOCK = rt.lock; ARCACHE = rt.cache; ARPROT = rt.prot;
    AWID = wt.id; AWADDR = wt.addr; AWLEN = wt.len; AWSIZE = wt.size;
    AWBURST = wt.burst; AWLOCK = wt.lock; AWCACHE = wt.cache; AWPROT = wt.prot;
    ARVALID = do_rd;
    AWVALID = do_wr;
    WVALID  = 1'b0;
    while (!done) begin
      if (!WVALID)
        WVALID = do_wr && (w_idx <= int'(wt.len)) && ($urandom_range(99) < 75);
      WDATA = wd[w_idx[3:0]];
      WSTRB = ws[w_idx[3:0]];
      WLAST = wl[w_idx[3:0]];
      stall = (burst && ((cycles >= 1 && cycles <= 5) || (cycles >= 9 && cycles <= 13)))
              || (int'($urandom_range(99)) < stall_pct);
      @(negedge clk);
      if (hdr_chk) begin
        checkOutput("hdr_latency", valid, 1);
        checkOutput("lut_address", lut_address, chk_nib);
        hdr_chk = 0;
      end
      ar_hs = ARVALID && ARREADY;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      xfer  = valid && !stall;
      idle  = (expq.size() == 0);
      if (ARVALID || AWVALID)
        checkOutput("ready", ar_hs || aw_hs, idle);
      if (xfer) begin
        if (expq.size() == 0) begin
          checkOutput("spurious_flit", xfer, 0);
        end else begin
          e = expq.pop_front();
          checkOutput(e.pay ? "payload_flit" : "header_flit", flit, e.f);
          checkOutput("w_sync", w_hs, e.pay);
          if (e.pay) pay_seen++;
        end
      end else if (w_hs) begin
        checkOutput("w_early", w_hs, 0);
      end
      if (ar_hs || aw_hs) begin
        exp_rd = ARVALID && (!AWVALID || !model_prio);
        checkOutput("accept_type", {ar_hs, aw_hs}, exp_rd ? 2'b10 : 2'b01);
        if (ar_hs) begin
          e.f = exp_header(1'b1, rt); e.pay = 0; expq.push_back(e);
          chk_nib = rt.addr[31:28];
        end else begin
          e.f = exp_header(1'b0, wt); e.pay = 0; expq.push_back(e);
          for (int i = 0; i <= int'(wt.len); i++) begin
            e.f = exp_payload(i, wt.len); e.pay = 1; expq.push_back(e);
            if (wl[i] != (i == int'(wt.len))) exp_err = 1'b1;
          end
          chk_nib = wt.addr[31:28];
        end
        model_prio = !model_prio;
        hdr_chk    = 1;
      end
      if (abort_after >= 0 && pay_seen >= abort_after) begin
        rst     = 1'b1;
        ARVALID = 1'b1;
        #1;
        checkOutput("abort_valid", valid, 0);
        checkOutput("abort_flit", flit, 0);
        checkOutput("abort_wready", WREADY, 0);
        checkOutput("abort_arready", ARREADY, 0);
        checkOutput("abort_wlast_err", wlast_err, 0);
        checkOutput("abort_lut_address", lut_address, 0);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        expq.delete();
        model_prio = 1'b0;
        exp_err    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (ar_hs) ARVALID = 1'b0;
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs) begin
        WVALID = 1'b0;
        w_idx++;
      end
      cycles++;
      if (!ARVALID && !AWVALID && expq.size() == 0) done = 1;
      if (!done && cycles >= 400) begin
        checkOutput("timeout", expq.size() + int'(ARVALID) + int'(AWVALID), 0);
        expq.delete();
        ARVALID = 1'b0; AWVALID = 1'b0;
        done = 1;
      end
    end
    WVALID = 1'b0;
    stall  = 1'b0;
    checkOutput("wlast_err", wlast_err, exp_err);
  endtask

  initial begin
    txn_t rt, wt;
    int   mode;
    rst = 1'b1; stall = 1'b0; SOURCE = 4'hA;
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    for (int i = 0; i < 16; i++) lut[i] = 7'($urandom);
    lut[2] = 7'h15;
    fill_wdata(4'd0, 1'b0);
    do_reset();

    rt = '{id:4'd3, addr:32'h2000_0040, len:4'd7, size:3'd3, burst:2'b01,
           lock:2'b00, cache:4'h3, prot:3'd2};
    applyStimulus(1'b1, 1'b0, rt, rt, 0, 1'b0, -1);

    wt = rand_txn(); wt.len = 4'd3;
    fill_wdata(wt.len, 1'b0);
    applyStimulus(1'b0, 1'b1, wt, wt, 0, 1'b0, -1);

    for (int k = 0; k < 2; k++) begin
      rt = rand_txn(); wt = rand_txn(); wt.len = 4'($urandom_range(3));
      fill_wdata(wt.len, 1'b0);
      applyStimulus(1'b1, 1'b1, rt, wt, 20, 1'b0, -1);
    end

    wt = rand_txn(); wt.len = 4'd5;
    fill_wdata(wt.len, 1'b0);
    applyStimulus(1'b0, 1'b1, wt, wt, 0, 1'b1, -1);
    rt = rand_txn();
    applyStimulus(1'b1, 1'b0, rt, rt, 0, 1'b1, -1);

    wt = rand_txn(); wt.len = 4'd1;
    fill_wdata(wt.len, 1'b0);
    wl[0] = 1'b1;
    wl[1] = 1'b0;
    applyStimulus(1'b0, 1'b1, wt, wt, 10, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < 20; k++) begin
        mode = int'($urandom_range(2));
        rt = rand_txn(); wt = rand_txn();
        fill_wdata(wt.len, $urandom_range(9) == 0);
        applyStimulus(mode != 1, mode != 0, rt, wt, 25, 1'b0, -1);
      end
    end

    do_reset();
    wt = rand_txn(); wt.len = 4'd8;
    fill_wdata(wt.len, 1'b1);
    applyStimulus(1'b0, 1'b1, wt, wt, 0, 1'b0, 2);
    rt = rand_txn();
    applyStimulus(1'b1, 1'b0, rt, rt, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_ni_request_packetizer.md
# axi_ni_request_packetizer

Request-side packetizer for the AXI NI initiator; the NoC-side counterpart to the NI target's request receiver. Accepts AXI3 AR and AW/W transactions from a master and emits 80-bit request flits (header plus write payload) into the NI output buffer. Route paths come from the per-initiator routing LUT through a combinational address/path pair. Responses travel on a separate path outside this block.

## Interface
- FLIT_WIDTH, 80: flit width; only 80 is supported.
- ID_WD, 4: AXI ID width.
- clk  in  1  NoC clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- SOURCE  in  4  this initiator's node ID, static.
- lut_address  out  4  destination index, equal to the captured address bits [31:28].
- lut_path  in  7  route returned by the LUT in the same cycle.
- flit  out  80  flit to the output buffer.
- valid  out  1  flit is valid (the output buffer's write).
- stall  in  1  output buffer full; a flit transfers when valid && !stall.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT  in  ID_WD/32/4/3/2/2/4/3  AXI read address channel.
- ARVALID in 1, ARREADY out 1  read address handshake.
- AWID..AWPROT  in  as for AR  AXI write address channel.
- AWVALID in 1, AWREADY out 1  write address handshake.
- WDATA in 64, WSTRB in 8, WLAST in 1, WVALID in 1, WREADY out 1  AXI write data channel (WID is ignored).
- wlast_err  out  1  sticky flag: WLAST disagreed with the beat count.

## Operation
- Flit type field, bits [1:0]: 01 = header, 00 = body, 10 = tail, 11 = header+tail.
- Header flit layout:
  - [79:73] path; [72:69] SOURCE; [68] is_read; [67] locked (LOCK==2'b10).
  - [66:63] ID; [62:31] ADDR; [30:27] LEN; [26:24] SIZE; [23:22] BURST; [21:18] CACHE; [17:15] PROT.
  - [14:2] zero.
- Payload flit layout: [79:16] WDATA; [15:8] WSTRB; [7] WLAST; [6:2] zero.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - ARREADY = ARVALID && (!AWVALID || prio==READ). AWREADY = AWVALID && (!ARVALID || prio==WRITE). Both are combinational.
  - On a handshake, capture the channel fields into the header register and go to HDR.
- HDR:
  - valid=1 and flit=header; path comes from lut_path at the captured address.
  - On transfer: a read goes to IDLE; a write clears the beat counter and goes to DATA.
  - On transfer, prio toggles to the other type.
- DATA:
  - valid=WVALID and WREADY=!stall; flit is built combinationally from W.
  - Type is 10 (tail) when beat==LEN, otherwise 00.
  - Each transfer increments the 4-bit beat counter. The transfer with beat==LEN returns the FSM to IDLE.
- Tail is decided by the counter only. On any transfer where WLAST != (beat==LEN), wlast_err is set; it clears only on rst.
- Reads always produce a single flit of type 11. A write produces LEN+2 flits; only the last is tail.

## Timing
- Reset values:
  - State IDLE; prio=READ; valid=0; flit=0.
  - ARREADY=AWREADY=WREADY=0; wlast_err=0; header register=0.
- Latency: an AR/AW handshake at cycle N puts the header valid at cycle N+1.
- The first W beat can transfer in the cycle after the header transfers. At best, one flit transfers per cycle.
- While stall=1 in HDR, flit and valid hold stable. In DATA, WREADY=0, so W is held by the master.
- ARVALID and AWVALID asserted in the same IDLE cycle: only the prio channel gets ready. prio starts READ, so a continuously contended bus alternates R, W, R.
- W beats arriving before the header transfers are not accepted; WREADY stays 0 outside DATA.
- LEN=0 write: header, then a single tail beat.
- An async rst mid-packet drops the partial packet immediately. The output buffer and the NoC are reset together, so no truncated packet is recovered.

## Structure
- Shared package/header (noc_parameters): flit type codes, header field offsets, and the LOCK encoding for locked accesses.
- Single module with no sub-modules; the routing LUT stays external, as in every NI.

## Test plan
- Reset, then ARVALID with ID=3, ADDR=0x2000_0040, LEN=7, lut_path=0x15 -> ARREADY at cycle 0; one flit at cycle 1 with [1:0]=11, [68]=1, [79:73]=0x15, lut_address=2.
- AW LEN=3 plus 4 W beats with WLAST on the 4th -> 5 flits with types 01,00,00,10; WSTRB lands in [15:8]; wlast_err stays 0.
- ARVALID and AWVALID held high together after reset -> accept order R, W, R; no W beat accepted before its header transfers.
- stall=1 for 5 cycles during HDR and mid-DATA -> flit stable, WREADY=0, no beat lost or duplicated after release.
- AW LEN=1 with WLAST on beat 0 -> wlast_err=1; tail still on beat 1; packet is 3 flits.
- rst asserted mid-DATA -> outputs return to reset values in the same cycle; the next AR is packetized normally.
